// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state type and counter-width helper for the fetch front end
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {pc, instr} entries with flush
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4,
   localparam int CW        = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [ADDR_WIDTH-1:0] i_push_pc,
   input  logic [DATA_WIDTH-1:0] i_push_instr,
   input  logic                  i_pop,
   input  logic                  i_clear,
   output logic [ADDR_WIDTH-1:0] o_head_pc,
   output logic [DATA_WIDTH-1:0] o_head_instr,
   output logic [CW-1:0]         o_count,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
   logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty      = (r_count == '0);
   assign o_full       = (r_count == CW'(DEPTH));
   assign o_count      = r_count;
   assign w_pop        = i_pop && !o_empty;
   assign w_push       = i_push && (!o_full || w_pop);
   assign o_head_pc    = r_pc_mem[r_rd_ptr];
   assign o_head_instr = o_empty ? INSTR_NOP : r_instr_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_clear) begin
         r_pc_mem[r_wr_ptr]    <= i_push_pc;
         r_instr_mem[r_wr_ptr] <= i_push_instr;
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - decoupled instruction fetch with in-order response queue and redirect flush
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trigger,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [ADDR_WIDTH-1:0] out_pcplus4
);

   localparam int             CW      = cnt_width(DEPTH);
   localparam logic [0:0]     ST_IDLE = IDLE;
   localparam logic [0:0]     ST_RUN  = RUN;

   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_rsp_pc;
   logic [CW-1:0]         r_inflight;
   logic [CW-1:0]         r_drop;

   logic                  w_accept;
   logic                  w_keep_rsp;
   logic                  w_credit_ok;
   logic [CW-1:0]         w_occupancy;
   logic [CW:0]           w_committed;
   logic [CW-1:0]         w_inflight_next;
   logic [ADDR_WIDTH-1:0] w_redirect_pc;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;

   // Wrong-path requests still hold a credit until their response returns.
   assign w_committed     = {1'b0, w_occupancy} + {1'b0, r_inflight};
   assign w_credit_ok     = (w_committed < (CW+1)'(DEPTH));
   assign imem_req_valid  = (r_state == ST_RUN) && w_credit_ok;
   assign imem_req_addr   = r_fetch_pc;
   assign w_accept        = imem_req_valid && imem_req_ready;
   assign w_keep_rsp      = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
   assign w_inflight_next = r_inflight + CW'(w_accept) - CW'(imem_rsp_valid);
   assign w_redirect_pc   = redirect_pc & ~ADDR_WIDTH'(3);

   assign out_valid   = !w_fifo_empty;
   assign out_pcplus4 = out_pc + ADDR_WIDTH'(4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (trigger) r_state <= ST_RUN;
            default: if (!trigger && !(imem_req_valid && !imem_req_ready)) r_state <= ST_IDLE;
         endcase

         r_inflight <= w_inflight_next;

         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_drop     <= w_inflight_next;
         end else begin
            if (w_accept)   r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            if (w_keep_rsp) r_rsp_pc   <= r_rsp_pc + ADDR_WIDTH'(4);
            if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_no_overflow: assert (!(w_keep_rsp && w_fifo_full && !out_ready));
         a_drop_bound:  assert (r_drop <= r_inflight);
      end
   end

   fetch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst),
      .i_push       (w_keep_rsp),
      .i_push_pc    (r_rsp_pc),
      .i_push_instr (imem_rsp_data),
      .i_pop        (out_ready),
      .i_clear      (redirect_valid),
      .o_head_pc    (out_pc),
      .o_head_instr (out_instr),
      .o_count      (w_occupancy),
      .o_full       (w_fifo_full),
      .o_empty      (w_fifo_empty)
   );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

   localparam int          DW     = 32;
   localparam int          AW     = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          trigger;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_req_addr;
   logic          imem_rsp_valid;
   logic [DW-1:0] imem_rsp_data;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_instr;
   logic [AW-1:0] out_pc;
   logic [AW-1:0] out_pcplus4;

   instr_fetch_queue #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .trigger        (trigger),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pcplus4    (out_pcplus4)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

   req_t        pend[$];
   ent_t        exp_q[$];
   int          n_err = 0;
   int          n_chk = 0;
   int          cyc = 0;
   int          epoch = 0;
   logic [31:0] exp_pc = RST_PC;
   bit          run = 0;
   bit          in_reset = 1;
   int          p_trig = 0, p_ready = 100, p_out = 100, p_redir = 0;
   int          lat_min = 1, lat_max = 1;
   bit          force_redir = 0;
   logic [31:0] force_pc = '0;
   int          first_acc = -1, first_val = -1, n_acc = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One clock of stimulus plus the reference model's view of that edge.
   task automatic step();
      bit          acc, rsp, rd, exp_rv;
      req_t        r, h;
      logic [31:0] rd_pc;
      @(negedge clk);
      exp_rv = run && ((exp_q.size() + pend.size()) < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
      trigger        = ($urandom_range(99) < p_trig);
      imem_req_ready = ($urandom_range(99) < p_ready);
      out_ready      = ($urandom_range(99) < p_out);
      rd             = force_redir || ($urandom_range(99) < p_redir);
      rd_pc          = force_redir ? force_pc : $urandom;
      force_redir    = 0;
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
         r.addr  = imem_req_addr;
         r.epoch = epoch;
         r.due   = cyc + int'($urandom_range(lat_max, lat_min));
         pend.push_back(r);
         n_acc++;
         if (first_acc < 0) first_acc = cyc;
      end
      rsp = (pend.size() > 0) && (pend[0].due <= cyc);
      if (rsp) h = pend.pop_front();
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem_word(h.addr) : $urandom;
      redirect_valid = rd;
      redirect_pc    = rd_pc;
      #3;
      if (rsp && !rd && h.epoch == epoch)
         exp_q.push_back('{pc: h.addr, instr: mem_word(h.addr)});
      if (rd) begin
         exp_q.delete();
         epoch++;
         exp_pc = rd_pc & ~32'd3;
      end else if (acc) begin
         exp_pc = exp_pc + 32'd4;
      end
      run = run ? (trigger || (imem_req_valid && !imem_req_ready)) : trigger;
      cyc++;
   endtask

   initial begin : monitor
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!in_reset) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && first_val < 0) first_val = cyc;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL unexpected_output: got pc %h, expected no output", out_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("out_pc", out_pc, e.pc);
                  check("out_instr", out_instr, e.instr);
                  check("out_pcplus4", out_pcplus4, e.pc + 32'd4);
               end
            end
         end
      end
   end

   initial begin : driver
      int n;
      rst = 1; trigger = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
      redirect_valid = 0; redirect_pc = '0; out_ready = 0;
      #1 rst = 0;
      #1;
      check("reset_req_valid", 32'(imem_req_valid), 32'd0);
      check("reset_req_addr", imem_req_addr, RST_PC);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1;
      in_reset = 0;

      // steady stream, latency 1, always ready
      p_trig = 100; first_acc = -1; first_val = -1;
      repeat (20) step();
      check("first_out_latency", 32'(first_val - first_acc), 32'd2);

      // drain, then fill with consumer stalled and zero latency
      p_trig = 0;
      repeat (10) step();
      p_trig = 100; p_out = 0; lat_min = 0; lat_max = 0; n_acc = 0;
      repeat (12) step();
      check("credit_accepts", 32'(n_acc), 32'(DEPTH));
      p_out = 100;
      repeat (6) step();

      // redirect with three requests in flight
      lat_min = 8; lat_max = 8; n = 0;
      while (pend.size() < 3 && n < 40) begin step(); n++; end
      check("inflight_setup", 32'(pend.size()), 32'd3);
      p_ready = 0; force_redir = 1; force_pc = 32'h0000_0103;
      step();
      p_ready = 100; lat_min = 1; lat_max = 1;
      repeat (20) step();

      // redirect coinciding with a response and an accept
      repeat (5) step();
      force_redir = 1; force_pc = 32'h0000_0200;
      repeat (12) step();

      // memory stall while trigger falls
      p_ready = 0;
      repeat (2) step();
      p_trig = 0;
      repeat (3) step();
      p_ready = 100;
      repeat (5) step();
      check("idle_after_trigger_low", 32'(imem_req_valid), 32'd0);

      // address wrap
      p_trig = 100; force_redir = 1; force_pc = 32'hFFFF_FFFC;
      repeat (12) step();

      // random traffic
      p_trig = 90; p_ready = 70; p_out = 60; p_redir = 4; lat_min = 0; lat_max = 3;
      repeat (400) step();
      p_redir = 0;

      // asynchronous reset in the middle of a burst
      p_trig = 100; p_ready = 100; p_out = 50; lat_min = 1; lat_max = 1;
      repeat (6) step();
      #4;
      rst = 0;
      in_reset = 1;
      #1;
      check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      check("midrst_req_addr", imem_req_addr, RST_PC);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      pend.delete(); exp_q.delete(); exp_pc = RST_PC; run = 0;
      trigger = 0; imem_rsp_valid = 0; redirect_valid = 0; out_ready = 0;
      @(negedge clk);
      rst = 1;
      in_reset = 0;
      repeat (15) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
